// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes (common with the ALU),
// FSM state encoding and opcode classification helpers.
package alu_seq_pkg;

    localparam int REG_AW_DEF = 3;
    localparam int DW_DEF     = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_XNOR = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_SUBI = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_LD1  = 4'd1,
        ST_LAT1 = 4'd2,
        ST_LD2  = 4'd3,
        ST_LAT2 = 4'd4,
        ST_EXEC = 4'd5,
        ST_WB   = 4'd6,
        ST_WBL  = 4'd7,
        ST_DONE = 4'd8
    } state_t;

    function automatic logic is_imm_op(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    function automatic logic is_unary_op(input logic [3:0] op);
        return (op == OP_NOT);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_SUBI);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Decode-side request and ALU/register-file control bundle of the sequencer.
interface alu_seq_if #(
    parameter int REG_AW = 3,
    parameter int DW     = 16
);
    logic              start;
    logic [3:0]        op;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [REG_AW-1:0] dst;
    logic [DW-1:0]     imm;
    logic              busy;
    logic              done;
    logic              err;
    logic [REG_AW-1:0] rf_rsel;
    logic              rf_oe;
    logic [REG_AW-1:0] rf_wsel;
    logic              rf_we;
    logic [DW-1:0]     imm_val;
    logic              imm_oe;
    logic              alu_en1;
    logic              alu_en2;
    logic [3:0]        alu_op;
    logic              alu_oe;
    logic [15:0]       op_count;

    modport master (
        output start, op, src1, src2, dst, imm,
        input  busy, done, err, rf_rsel, rf_oe, rf_wsel, rf_we, imm_val,
               imm_oe, alu_en1, alu_en2, alu_op, alu_oe, op_count
    );

    modport slave (
        input  start, op, src1, src2, dst, imm,
        output busy, done, err, rf_rsel, rf_oe, rf_wsel, rf_we, imm_val,
               imm_oe, alu_en1, alu_en2, alu_op, alu_oe, op_count
    );
endinterface

// File: rtl/alu_seq_busdrv.sv
// Registered output decode for the ALU sequencer. It is fed the FSM's next
// state and next captured fields, so every output flop lines up with the
// state register and no combinational path reaches the bus enables.
module alu_seq_busdrv
    import alu_seq_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  state_t            i_state,
    input  logic [3:0]        i_op,
    input  logic [REG_AW-1:0] i_src1,
    input  logic [REG_AW-1:0] i_src2,
    input  logic [REG_AW-1:0] i_dst,
    input  logic [DW-1:0]     i_imm,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [REG_AW-1:0] o_rf_rsel,
    output logic              o_rf_oe,
    output logic [REG_AW-1:0] o_rf_wsel,
    output logic              o_rf_we,
    output logic [DW-1:0]     o_imm_val,
    output logic              o_imm_oe,
    output logic              o_alu_en1,
    output logic              o_alu_en2,
    output logic [3:0]        o_alu_op,
    output logic              o_alu_oe
);

    logic w_rd1, w_rd2, w_use_imm;

    // Select which of the three bus drivers owns each state; at most one wins.
    always_comb begin
        w_rd1     = (i_state == ST_LD1) || (i_state == ST_LAT1);
        w_rd2     = (i_state == ST_LD2) || (i_state == ST_LAT2);
        w_use_imm = w_rd2 && is_imm_op(i_op);
    end

    // Register the decoded enables, strobes and selects; reset forces all low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_rf_rsel <= '0;
            o_rf_oe   <= 1'b0;
            o_rf_wsel <= '0;
            o_rf_we   <= 1'b0;
            o_imm_val <= '0;
            o_imm_oe  <= 1'b0;
            o_alu_en1 <= 1'b0;
            o_alu_en2 <= 1'b0;
            o_alu_op  <= '0;
            o_alu_oe  <= 1'b0;
        end else begin
            o_busy    <= (i_state != ST_IDLE);
            o_done    <= (i_state == ST_DONE);
            o_err     <= (i_state == ST_DONE) && !is_legal_op(i_op);
            o_rf_oe   <= w_rd1 || (w_rd2 && !w_use_imm);
            o_rf_rsel <= w_rd1 ? i_src1 : ((w_rd2 && !w_use_imm) ? i_src2 : '0);
            o_imm_oe  <= w_use_imm;
            o_imm_val <= w_use_imm ? i_imm : '0;
            o_alu_en1 <= (i_state == ST_LAT1);
            o_alu_en2 <= (i_state == ST_LAT2);
            o_alu_op  <= (i_state != ST_IDLE) ? i_op : 4'd0;
            o_alu_oe  <= (i_state == ST_WB) || (i_state == ST_WBL);
            o_rf_we   <= (i_state == ST_WBL);
            o_rf_wsel <= (i_state == ST_WBL) ? i_dst : '0;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU operation sequencer over a shared bus.
// Optional feature macro: ALU_SEQ_OPCOUNT_EN (completed-operation counter).
//
// state | meaning
// IDLE  | waiting for start; request fields captured on acceptance
// LD1   | register file drives src1 onto the bus
// LAT1  | src1 still driven, ALU operand-1 strobe
// LD2   | src2 (or immediate) driven onto the bus
// LAT2  | same driver, ALU operand-2 strobe
// EXEC  | bus idle while the ALU settles
// WB    | ALU drives result onto the bus
// WBL   | ALU still driving, register-file write strobe
// DONE  | completion pulse (err for illegal opcodes)
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_op, w_op_nxt;
    logic [REG_AW-1:0] r_src1, w_src1_nxt;
    logic [REG_AW-1:0] r_src2, w_src2_nxt;
    logic [REG_AW-1:0] r_dst, w_dst_nxt;
    logic [DW-1:0]     r_imm, w_imm_nxt;

    // State and captured request fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_src1  <= '0;
            r_src2  <= '0;
            r_dst   <= '0;
            r_imm   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_src1  <= w_src1_nxt;
            r_src2  <= w_src2_nxt;
            r_dst   <= w_dst_nxt;
            r_imm   <= w_imm_nxt;
        end
    end

    // Next-state logic; a request is only captured while IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_src1_nxt  = r_src1;
        w_src2_nxt  = r_src2;
        w_dst_nxt   = r_dst;
        w_imm_nxt   = r_imm;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_op_nxt    = bus.op;
                    w_src1_nxt  = bus.src1;
                    w_src2_nxt  = bus.src2;
                    w_dst_nxt   = bus.dst;
                    w_imm_nxt   = bus.imm;
                    w_state_nxt = is_legal_op(bus.op) ? ST_LD1 : ST_DONE;
                end
            end
            ST_LD1:  w_state_nxt = ST_LAT1;
            ST_LAT1: w_state_nxt = is_unary_op(r_op) ? ST_EXEC : ST_LD2;
            ST_LD2:  w_state_nxt = ST_LAT2;
            ST_LAT2: w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_WB;
            ST_WB:   w_state_nxt = ST_WBL;
            ST_WBL:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    alu_seq_busdrv #(
        .REG_AW (REG_AW),
        .DW     (DW)
    ) u_busdrv (
        .clk       (clk),
        .reset     (reset),
        .i_state   (w_state_nxt),
        .i_op      (w_op_nxt),
        .i_src1    (w_src1_nxt),
        .i_src2    (w_src2_nxt),
        .i_dst     (w_dst_nxt),
        .i_imm     (w_imm_nxt),
        .o_busy    (bus.busy),
        .o_done    (bus.done),
        .o_err     (bus.err),
        .o_rf_rsel (bus.rf_rsel),
        .o_rf_oe   (bus.rf_oe),
        .o_rf_wsel (bus.rf_wsel),
        .o_rf_we   (bus.rf_we),
        .o_imm_val (bus.imm_val),
        .o_imm_oe  (bus.imm_oe),
        .o_alu_en1 (bus.alu_en1),
        .o_alu_en2 (bus.alu_en2),
        .o_alu_op  (bus.alu_op),
        .o_alu_oe  (bus.alu_oe)
    );

`ifdef ALU_SEQ_OPCOUNT_EN
    logic [15:0] r_op_count;

    // Count successful completions as DONE is left; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_count <= '0;
        end else if ((r_state == ST_DONE) && is_legal_op(r_op)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign bus.op_count = r_op_count;
`else
    assign bus.op_count = 16'd0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: register file and ALU environment on the shared
// bus, per-cycle phase expectations and result checks from plain arithmetic.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errs = 0;
    int checks = 0;
    int model_cnt = 0;

    logic [15:0] rf [8];
    logic [15:0] a1, a2, bus_d;
    logic        pre_we = 1'b0;
    logic [2:0]  pre_a = 3'd0;
    logic [15:0] pre_d = 16'd0;

    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return ~a;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return ~(a ^ b);
            4'd7: return a + b;
            4'd8: return a - b;
            default: return 16'h0;
        endcase
    endfunction

    always_comb begin
        bus_d = 16'h0;
        if (bus.rf_oe)       bus_d = rf[bus.rf_rsel];
        else if (bus.imm_oe) bus_d = bus.imm_val;
        else if (bus.alu_oe) bus_d = alu_ref(bus.alu_op, a1, a2);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1 <= 16'h0;
            a2 <= 16'h0;
        end else begin
            if (bus.alu_en1) a1 <= bus_d;
            if (bus.alu_en2) a2 <= bus_d;
        end
    end

    always @(posedge clk) begin
        if (bus.rf_we)   rf[bus.rf_wsel] <= bus_d;
        else if (pre_we) rf[pre_a] <= pre_d;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
`ifdef ALU_SEQ_OPCOUNT_EN
        return model_cnt % 65536;
`else
        return 0;
`endif
    endfunction

    function automatic logic [63:0] obs();
        return {29'b0, bus.busy, bus.done, bus.err, bus.rf_oe, bus.rf_rsel, bus.imm_oe, bus.imm_val,
                bus.alu_en1, bus.alu_en2, bus.alu_op, bus.alu_oe, bus.rf_we, bus.rf_wsel};
    endfunction

    // Phases: 1 read src1, 2 latch op1, 3 load op2, 4 latch op2, 5 exec, 6 ALU out, 7 write, 8 done.
    function automatic logic [63:0] exp_vec(input logic [3:0] op, input logic [2:0] s1, input logic [2:0] s2,
                                            input logic [2:0] d, input logic [15:0] imm, input int ph);
        logic imm_op, rd1, ld2, busy, done, err, rf_oe, imm_oe, en1, en2, aoe, we;
        logic [2:0] rsel, wsel;
        logic [15:0] ival;
        logic [3:0] aop;
        imm_op = (op == OP_ADDI) || (op == OP_SUBI);
        rd1    = (ph == 1) || (ph == 2);
        ld2    = (ph == 3) || (ph == 4);
        busy   = (ph != 0);
        done   = (ph == 8);
        err    = done && (op > 4'd8);
        rf_oe  = rd1 || (ld2 && !imm_op);
        rsel   = rd1 ? s1 : ((ld2 && !imm_op) ? s2 : 3'd0);
        imm_oe = ld2 && imm_op;
        ival   = imm_oe ? imm : 16'h0;
        en1    = (ph == 2);
        en2    = (ph == 4);
        aop    = busy ? op : 4'd0;
        aoe    = (ph == 6) || (ph == 7);
        we     = (ph == 7);
        wsel   = we ? d : 3'd0;
        return {29'b0, busy, done, err, rf_oe, rsel, imm_oe, ival, en1, en2, aop, aoe, we, wsel};
    endfunction

    task automatic preset(input logic [2:0] a, input logic [15:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Called on a negedge with the sequencer idle; returns on a negedge.
    task automatic run_op(input logic [3:0] op, input logic [2:0] s1, input logic [2:0] s2,
                          input logic [2:0] d, input logic [15:0] imm, input int abort_ph);
        int seq[$];
        logic [15:0] a, b, old;
        chk("idle", obs(), 64'd0);
        chk("op_count", 64'(bus.op_count), 64'(exp_cnt()));
        a   = rf[s1];
        b   = ((op == OP_ADDI) || (op == OP_SUBI)) ? imm : rf[s2];
        old = rf[d];
        if (op > 4'd8)        seq = '{8};
        else if (op == OP_NOT) seq = '{1, 2, 5, 6, 7, 8};
        else                  seq = '{1, 2, 3, 4, 5, 6, 7, 8};
        bus.start = 1'b1;
        bus.op    = op;
        bus.src1  = s1;
        bus.src2  = s2;
        bus.dst   = d;
        bus.imm   = imm;
        foreach (seq[k]) begin
            @(negedge clk);
            chk("phase", obs(), exp_vec(op, s1, s2, d, imm, seq[k]));
            chk("bus_excl", 64'($countones({bus.rf_oe, bus.imm_oe, bus.alu_oe}) <= 1), 64'd1);
            bus.start = 1'($urandom);
            bus.op    = 4'($urandom);
            bus.src1  = 3'($urandom);
            bus.src2  = 3'($urandom);
            bus.dst   = 3'($urandom);
            bus.imm   = 16'($urandom);
            if (seq[k] == abort_ph) begin
                reset = 1'b0;
                #1;
                chk("rst_async", obs(), 64'd0);
                model_cnt = 0;
                chk("rst_count", 64'(bus.op_count), 64'd0);
                @(negedge clk);
                reset = 1'b1;
                bus.start = 1'b0;
                return;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        if (op <= 4'd8) begin
            chk("rf_result", 64'(rf[d]), 64'(alu_ref(op, a, b)));
            model_cnt++;
        end else begin
            chk("rf_keep", 64'(rf[d]), 64'(old));
        end
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [2:0]  r_s1, r_s2, r_d;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.src1  = 3'd0;
        bus.src2  = 3'd0;
        bus.dst   = 3'd0;
        bus.imm   = 16'd0;
        for (int i = 0; i < 8; i++) preset(3'(i), 16'($urandom));
        chk("reset_outputs", obs(), 64'd0);
        chk("reset_count", 64'(bus.op_count), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        preset(3'd1, 16'h0003);
        preset(3'd2, 16'h0004);
        run_op(OP_ADD, 3'd1, 3'd2, 3'd3, 16'h0, 0);
        chk("add_r3", 64'(rf[3]), 64'h0007);

        preset(3'd1, 16'h0010);
        run_op(OP_SUBI, 3'd1, 3'd6, 3'd4, 16'h0001, 0);
        chk("subi_r4", 64'(rf[4]), 64'h000F);

        preset(3'd1, 16'h00FF);
        run_op(OP_NOT, 3'd1, 3'd2, 3'd5, 16'h0, 0);
        chk("not_r5", 64'(rf[5]), 64'hFF00);

        run_op(4'hC, 3'd1, 3'd2, 3'd6, 16'h0, 0);
`ifdef ALU_SEQ_OPCOUNT_EN
        chk("count_after_4", 64'(bus.op_count), 64'd3);
`else
        chk("count_after_4", 64'(bus.op_count), 64'd0);
`endif

        preset(3'd1, 16'h1234);
        preset(3'd2, 16'h0101);
        run_op(OP_ADD, 3'd1, 3'd2, 3'd7, 16'h0, 4);
        run_op(OP_ADD, 3'd1, 3'd2, 3'd7, 16'h0, 0);
        chk("add_after_reset", 64'(rf[7]), 64'h1335);

        repeat (40) begin
            if ($urandom_range(0, 3) == 0) preset(3'($urandom), 16'($urandom));
            r_op = 4'($urandom_range(0, 11));
            r_s1 = 3'($urandom);
            r_s2 = 3'($urandom);
            r_d  = 3'($urandom);
            run_op(r_op, r_s1, r_s2, r_d, 16'($urandom), 0);
        end

        chk("final_idle", obs(), 64'd0);
        chk("final_count", 64'(bus.op_count), 64'(exp_cnt()));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
